// File: rtl/sram_rw_port_ctrl.sv
// Initiator for a single-port masked SRAM: merges write and read request channels onto
// the RW port and returns read data in request order through a small response queue.
module sram_rw_port_ctrl #(
    parameter int DEPTH         = 32,
    parameter int AW            = 5,
    parameter int WIDTH         = 516,
    parameter int SEGS          = 2,
    parameter int RQ_DEPTH      = 2,
    parameter int INIT_ON_RESET = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [AW-1:0]    w_addr,
    input  logic [SEGS-1:0]  w_mask,
    input  logic [WIDTH-1:0] w_data,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [AW-1:0]    r_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             init_done,
    output logic [AW-1:0]    sram_addr,
    output logic             sram_en,
    output logic             sram_wmode,
    output logic [SEGS-1:0]  sram_wmask,
    output logic [WIDTH-1:0] sram_wdata,
    input  logic [WIDTH-1:0] sram_rdata
);

    localparam int QW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam int CW = $clog2(RQ_DEPTH + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    init_ctr, init_ctr_nxt;
    logic             arb_rd_first, arb_rd_first_nxt;
    logic             inflight;
    logic [WIDTH-1:0] q_mem [RQ_DEPTH];
    logic [QW-1:0]    q_head, q_tail;
    logic [CW-1:0]    q_occ;
    logic             q_push, q_pop;
    logic             w_elig, r_elig, w_grant, r_grant, rd_ok;
    int               credit_used;

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
        return (p == QW'(RQ_DEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    assign resp_valid = reset_n && (q_occ != '0);
    assign resp_data  = q_mem[q_head];
    assign q_pop      = resp_valid && resp_ready;
    assign q_push     = inflight;
    assign init_done  = reset_n && (state == ST_RUN);
    assign w_ready    = w_grant;
    assign r_ready    = r_grant;

    // A response popped this cycle frees its slot for a read granted in the same cycle.
    assign credit_used = int'(q_occ) + int'(inflight) - int'(q_pop);
    assign rd_ok       = credit_used < RQ_DEPTH;

    always_comb begin
        state_nxt        = state;
        init_ctr_nxt     = init_ctr;
        arb_rd_first_nxt = arb_rd_first;
        w_elig           = 1'b0;
        r_elig           = 1'b0;
        w_grant          = 1'b0;
        r_grant          = 1'b0;
        sram_en          = 1'b0;
        sram_wmode       = 1'b0;
        sram_addr        = '0;
        sram_wmask       = '0;
        sram_wdata       = '0;
        if (reset_n) begin
            unique case (state)
                ST_INIT: begin
                    sram_en      = 1'b1;
                    sram_wmode   = 1'b1;
                    sram_wmask   = '1;
                    sram_addr    = init_ctr;
                    init_ctr_nxt = init_ctr + AW'(1);
                    if (init_ctr == AW'(DEPTH - 1)) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_elig = w_valid;
                    r_elig = r_valid && rd_ok;
                    if (w_elig && r_elig) begin
                        r_grant          = arb_rd_first;
                        w_grant          = !arb_rd_first;
                        arb_rd_first_nxt = !arb_rd_first;
                    end else begin
                        w_grant = w_elig;
                        r_grant = r_elig;
                    end
                    if (w_grant) begin
                        sram_en    = 1'b1;
                        sram_wmode = 1'b1;
                        sram_addr  = w_addr;
                        sram_wmask = w_mask;
                        sram_wdata = w_data;
                    end else if (r_grant) begin
                        sram_en   = 1'b1;
                        sram_addr = r_addr;
                    end
                end
                default: begin
                    state_nxt = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_ctr     <= '0;
            arb_rd_first <= 1'b1;
            inflight     <= 1'b0;
            q_head       <= '0;
            q_tail       <= '0;
            q_occ        <= '0;
        end else begin
            state        <= state_nxt;
            init_ctr     <= init_ctr_nxt;
            arb_rd_first <= arb_rd_first_nxt;
            inflight     <= r_grant;
            if (q_push) begin
                q_tail <= q_inc(q_tail);
            end
            if (q_pop) begin
                q_head <= q_inc(q_head);
            end
            q_occ <= q_occ + CW'(q_push) - CW'(q_pop);
        end
    end

    // Read data lands the cycle after the read enable; capture it into the queue tail.
    always_ff @(posedge clock) begin
        if (reset_n && q_push) begin
            q_mem[q_tail] <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Self-checking bench for sram_rw_port_ctrl: behavioural SRAM macro plus a shadow-array /
// expected-response-queue reference model checked every cycle, driven by directed and random steps.
module tb_sram_rw_port_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int WIDTH = 516;
    localparam int SEGS  = 2;
    localparam int RQ    = 2;
    localparam int G     = WIDTH / SEGS;

    logic             clock;
    logic             reset_n;
    logic             w_valid, w_ready;
    logic [AW-1:0]    w_addr;
    logic [SEGS-1:0]  w_mask;
    logic [WIDTH-1:0] w_data;
    logic             r_valid, r_ready;
    logic [AW-1:0]    r_addr;
    logic             resp_valid, resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             init_done;
    logic [AW-1:0]    sram_addr;
    logic             sram_en, sram_wmode;
    logic [SEGS-1:0]  sram_wmask;
    logic [WIDTH-1:0] sram_wdata, sram_rdata;

    sram_rw_port_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .WIDTH(WIDTH), .SEGS(SEGS),
        .RQ_DEPTH(RQ), .INIT_ON_RESET(1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
        .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .init_done(init_done),
        .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w = '0;
        for (int i = 0; i < (WIDTH + 31) / 32; i++) begin
            w = {w[WIDTH-33:0], 32'($urandom)};
        end
        return w;
    endfunction

    // SRAM macro: masked write, 1-cycle read; rdata is garbage on non-read cycles.
    logic [WIDTH-1:0] sram_mem [DEPTH];
    logic             seeded = 1'b0;
    always @(posedge clock) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= rand_word();
            sram_rdata <= rand_word();
            seeded     <= 1'b1;
        end else if (sram_en && sram_wmode) begin
            for (int s = 0; s < SEGS; s++) begin
                if (sram_wmask[s]) sram_mem[sram_addr][s*G +: G] <= sram_wdata[s*G +: G];
            end
            sram_rdata <= rand_word();
        end else if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr];
        end else begin
            sram_rdata <= rand_word();
        end
    end

    typedef struct {
        logic [WIDTH-1:0] data;
        int unsigned      at;
    } exp_t;

    logic [WIDTH-1:0] shadow [DEPTH];
    exp_t             exp_q[$];
    int unsigned      pop_cycles[$];
    int unsigned      now = 0;
    int unsigned      init_cnt = 0;
    logic             mdl_rd_first = 1'b1;
    int               n_chk = 0;
    int               n_fail = 0;
    logic             last_w_fire, last_r_fire, samp_r_ready;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, update model, step to posedge+1.
    task automatic cyc();
        logic exp_rv, pop, r_elig, exp_w, exp_r;
        exp_t e;
        @(negedge clock);
        last_w_fire  = w_valid && w_ready;
        last_r_fire  = r_valid && r_ready;
        samp_r_ready = r_ready;
        if (!reset_n) begin
            chk("rst_en", sram_en, 0);
            chk("rst_w_ready", w_ready, 0);
            chk("rst_r_ready", r_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_init_done", init_done, 0);
            init_cnt = 0;
            exp_q.delete();
            mdl_rd_first = 1'b1;
            for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        end else if (init_cnt < DEPTH) begin
            chk("init_done_low", init_done, 0);
            chk("init_en", sram_en, 1);
            chk("init_wmode", sram_wmode, 1);
            chk("init_addr", sram_addr, init_cnt);
            chk("init_mask", sram_wmask, {SEGS{1'b1}});
            chk("init_wdata", sram_wdata, 0);
            chk("init_w_ready", w_ready, 0);
            chk("init_r_ready", r_ready, 0);
            chk("init_resp_valid", resp_valid, 0);
            init_cnt++;
        end else begin
            chk("init_done", init_done, 1);
            exp_rv = (exp_q.size() > 0) && (exp_q[0].at + 2 <= now);
            chk("resp_valid", resp_valid, exp_rv);
            pop    = exp_rv && resp_ready;
            r_elig = r_valid && ((exp_q.size() - int'(pop)) < RQ);
            if (w_valid && r_elig) begin
                exp_r        = mdl_rd_first;
                exp_w        = !mdl_rd_first;
                mdl_rd_first = !mdl_rd_first;
            end else begin
                exp_w = w_valid;
                exp_r = r_elig;
            end
            chk("w_ready", w_ready, exp_w);
            chk("r_ready", r_ready, exp_r);
            if (exp_w) begin
                chk("wr_en", sram_en, 1);
                chk("wr_wmode", sram_wmode, 1);
                chk("wr_addr", sram_addr, w_addr);
                chk("wr_mask", sram_wmask, w_mask);
                chk("wr_data", sram_wdata, w_data);
                for (int s = 0; s < SEGS; s++) begin
                    if (w_mask[s]) shadow[w_addr][s*G +: G] = w_data[s*G +: G];
                end
            end else if (exp_r) begin
                chk("rd_en", sram_en, 1);
                chk("rd_wmode", sram_wmode, 0);
                chk("rd_addr", sram_addr, r_addr);
                chk("rd_mask", sram_wmask, 0);
                chk("rd_wdata", sram_wdata, 0);
            end else begin
                chk("idle_en", sram_en, 0);
                chk("idle_addr", sram_addr, 0);
                chk("idle_mask", sram_wmask, 0);
                chk("idle_wdata", sram_wdata, 0);
            end
            if (pop) begin
                chk("resp_data", resp_data, exp_q[0].data);
                void'(exp_q.pop_front());
                pop_cycles.push_back(now);
            end
            if (exp_r) begin
                e.data = shadow[r_addr];
                e.at   = now;
                exp_q.push_back(e);
            end
        end
        now++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [SEGS-1:0] m,
                            input logic [WIDTH-1:0] d, output int used);
        w_valid = 1'b1; w_addr = a; w_mask = m; w_data = d;
        used = 0;
        do begin
            cyc();
            used++;
        end while (!last_w_fire && used < 40);
        chk("write_accepted", last_w_fire, 1);
        w_valid = 1'b0;
    endtask

    // Single read with the queue idle: response must appear exactly two cycles after accept.
    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] expv);
        int n = 0;
        r_valid = 1'b1; r_addr = a; resp_ready = 1'b1;
        do begin
            cyc();
            n++;
        end while (!last_r_fire && n < 40);
        chk({tag, "_accepted"}, last_r_fire, 1);
        r_valid = 1'b0;
        chk({tag, "_lat_t1"}, resp_valid, 0);
        cyc();
        chk({tag, "_lat_t2"}, resp_valid, 1);
        chk({tag, "_data"}, resp_data, expv);
        cyc();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        r_valid = 1'b0; w_valid = 1'b0; resp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] da, db, expd;
        int used, n_acc;

        reset_n = 1'b0; w_valid = 1'b1; r_valid = 1'b1; resp_ready = 1'b1;
        w_addr = '0; w_mask = '1; w_data = rand_word(); r_addr = '0;

        // 1: reset, init sweep, readback of zero
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (DEPTH) cyc();
        w_valid = 1'b0; r_valid = 1'b0;
        chk("t1_init_done_c33", init_done, 1);
        read_check("t1_read7", 5'd7, '0);

        // 2: two half-masked writes merge
        da = rand_word(); db = rand_word();
        do_write(5'd3, 2'b01, da, used);
        do_write(5'd3, 2'b10, db, used);
        expd = {db[WIDTH-1:G], da[G-1:0]};
        read_check("t2_merge", 5'd3, expd);

        // 3: back-to-back reads with a ready consumer
        for (int i = 0; i < 8; i++) do_write(AW'(i), 2'($urandom_range(0, 3)), rand_word(), used);
        pop_cycles.delete();
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r_valid = 1'b1; r_addr = AW'(i);
            cyc();
            chk("t3_r_ready", samp_r_ready, 1);
        end
        r_valid = 1'b0;
        repeat (3) cyc();
        chk("t3_n_resp", pop_cycles.size(), 8);
        for (int k = 1; k < pop_cycles.size(); k++) chk("t3_consec", pop_cycles[k] - pop_cycles[k-1], 1);

        // 4: stalled consumer caps accepted reads at queue depth; writes still flow
        resp_ready = 1'b0; n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            r_valid = 1'b1; r_addr = AW'($urandom_range(0, 7));
            cyc();
            n_acc += int'(last_r_fire);
        end
        chk("t4_accepted", n_acc, RQ);
        chk("t4_r_ready_low", samp_r_ready, 0);
        do_write(AW'($urandom_range(0, 7)), 2'b11, rand_word(), used);
        chk("t4_write_no_credit", used, 1);
        pop_cycles.delete();
        drain("t4");
        chk("t4_n_drained", pop_cycles.size(), RQ);

        // 5: both channels held -> strict alternation starting with read
        resp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w_valid = 1'b1; r_valid = 1'b1;
            w_addr = AW'($urandom_range(0, 3)); r_addr = AW'($urandom_range(0, 3));
            w_mask = 2'($urandom_range(0, 3)); w_data = rand_word();
            cyc();
            chk("t5_r_grant", last_r_fire, (k % 2) == 0);
            chk("t5_w_grant", last_w_fire, (k % 2) == 1);
        end
        drain("t5");

        // random traffic over a small address window
        for (int k = 0; k < 300; k++) begin
            w_valid    = ($urandom_range(0, 99) < 50);
            r_valid    = ($urandom_range(0, 99) < 60);
            resp_ready = ($urandom_range(0, 99) < 70);
            w_addr = AW'($urandom_range(0, 7)); r_addr = AW'($urandom_range(0, 7));
            w_mask = 2'($urandom_range(0, 3)); w_data = rand_word();
            cyc();
        end
        drain("rand");

        // 6: reset with one queued and one in-flight read
        resp_ready = 1'b0; r_valid = 1'b1; r_addr = 5'd1;
        cyc();
        cyc();
        r_valid = 1'b0;
        chk("t6_queued", resp_valid, 1);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        repeat (DEPTH) cyc();
        chk("t6_init_done", init_done, 1);
        resp_ready = 1'b1;
        repeat (10) cyc();
        read_check("t6_read1", 5'd1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
